data_cache: RTL and testbench
=============================

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache between the CPU memory stage and the 2048 x 64-bit RAM.
- Serves read hits in one cycle.
- Sequences read fills and write-throughs onto the RAM's level-sensitive address/isReading/dataIn/dataOut interface.
- One outstanding request at a time; valid/ready request handshake plus a response pulse.

Parameters:
- ADDR_WIDTH, 11: word address width; matches the RAM.
- DATA_WIDTH, 64: word width.
- INDEX_BITS, 6: 64 lines of one word each. Tag = upper ADDR_WIDTH-INDEX_BITS (5) bits.
- RAM_LATENCY, 1: cycles RAM signals are held per access; minimum 1.

Ports:
- Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n. The polarity and synchronicity are fixed.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpuReq  in  1  request valid.
- cpuWrite  in  1  1 = write, 0 = read; sampled with cpuReq.
- cpuAddress  in  ADDR_WIDTH  word address.
- cpuWriteData  in  DATA_WIDTH  store data.
- cpuReady  out  1  high only in IDLE; request accepted on the edge where cpuReq and cpuReady are both high.
- cpuRespValid  out  1  one-cycle completion pulse for reads and writes.
- cpuReadData  out  DATA_WIDTH  read result, valid while cpuRespValid is high; otherwise holds its previous value.
- ramAddress  out  ADDR_WIDTH  latched request address.
- ramIsReading  out  1  0 only in WRITE; 1 in every other state, including during reset.
- ramDataIn  out  DATA_WIDTH  latched store data.
- ramDataOut  in  DATA_WIDTH  RAM read data.
- hitCount  out  16  read-hit counter, saturating at 0xFFFF.
- missCount  out  16  read-miss counter, saturating at 0xFFFF.

Behaviour:
- Reset (async assert, takes effect immediately):
  - state = IDLE; all valid bits cleared; cpuRespValid = 0.
  - cpuReadData = 0; ramAddress = 0; ramDataIn = 0; ramIsReading = 1.
  - hitCount = 0; missCount = 0; wait counter = 0.
- IDLE, read accepted, hit (valid[index] and tag match):
  - Accepting edge registers the line data into cpuReadData and sets cpuRespValid; latency 1 cycle.
  - hitCount increments; state stays IDLE.
- IDLE, read accepted, miss:
  - Latch address; missCount increments; go to FILL; counter = RAM_LATENCY-1.
- FILL:
  - Drive ramAddress with the latched address, ramIsReading = 1; decrement the counter each cycle.
  - On the edge where the counter is 0: write line data, tag and valid = 1 (evicting any other tag); cpuReadData <= ramDataOut; cpuRespValid <= 1; go to IDLE.
  - cpuRespValid rises RAM_LATENCY+1 cycles after the accepting edge.
- IDLE, write accepted:
  - Latch address and data; go to WRITE; counter = RAM_LATENCY-1.
- WRITE:
  - ramIsReading = 0 with address/data stable for RAM_LATENCY cycles.
  - On the final edge: if the line hits, update its data (no allocate on miss); cpuRespValid <= 1; go to IDLE. Hit/miss counters are not touched.
- Response cycle: cpuReady is already high, so a new request may be accepted in the same cycle cpuRespValid is asserted (back-to-back).
- cpuReq while not ready: ignored; the requester must hold it.
- ramAddress/ramDataIn change only on request acceptance, never while ramIsReading = 0. There are no spurious RAM writes.
- Counters hold at 0xFFFF.
- Reset mid-FILL or mid-WRITE: transaction abandoned, no response issued, ramIsReading returns to 1 asynchronously.

Decomposition:
- Shared package: state enum (IDLE, FILL, WRITE); ADDR_WIDTH/DATA_WIDTH constants shared with the RAM; helpers for tag and index field extraction.
- One sub-module, cache_line_store:
  - Tag/valid/data arrays; combinational read port; one synchronous write port.
  - Async clear of valid bits on rst_n.
- The FSM, counters and RAM drive stay in data_cache.

Test Plan:
1. Reset, RAM zeroed; write 0x000000000000FF04 to 1024 -> ramIsReading = 0 for RAM_LATENCY cycles, RAM[1024] = 0xFF04, one cpuRespValid pulse, hitCount = missCount = 0, line not allocated.
2. Read 1024 -> miss; cpuReadData = 0xFF04 with cpuRespValid RAM_LATENCY+1 cycles after acceptance; missCount = 1.
3. Read 1024 again -> hit; cpuRespValid the next cycle, data 0xFF04; ramIsReading stays 1; hitCount = 1.
4. Read 1088 (same index 0, different tag) then 1024 -> both miss, eviction confirmed; missCount = 3. Then read 1023 -> miss returning 0.
5. Write 0x1234 to cached 1024, then read 1024 -> RAM[1024] = 0x1234; the read is a hit returning 0x1234. Back-to-back requests issued in the response cycles are accepted.
6. Drop rst_n mid-FILL -> ramIsReading = 1 and cpuRespValid = 0 immediately; after release, cpuReady = 1 and a read of 1024 is a miss; counters = 0.

Source files
------------

// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared constants, state encoding and address field helpers for data_cache
package data_cache_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 64;
    localparam int INDEX_BITS = 6;
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;
    localparam int LINES      = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cacheState_t;

    function automatic logic [INDEX_BITS-1:0] getIndex(input logic [ADDR_WIDTH-1:0] address);
        return address[INDEX_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] getTag(input logic [ADDR_WIDTH-1:0] address);
        return address[ADDR_WIDTH-1:INDEX_BITS];
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU-side request/response bundle of data_cache
interface data_cache_if;
    import data_cache_pkg::*;

    logic                  cpuReq;
    logic                  cpuWrite;
    logic [ADDR_WIDTH-1:0] cpuAddress;
    logic [DATA_WIDTH-1:0] cpuWriteData;
    logic                  cpuReady;
    logic                  cpuRespValid;
    logic [DATA_WIDTH-1:0] cpuReadData;

    modport master (
        output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        input  cpuReady, cpuRespValid, cpuReadData
    );

    modport slave (
        input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        output cpuReady, cpuRespValid, cpuReadData
    );

endinterface

// File: rtl/data_cache_cache_line_store.sv
// rtl/data_cache_cache_line_store.sv - direct-mapped tag/valid/data arrays, one combinational read port, one write port
module cache_line_store
    import data_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rdIndex,
    output logic                  rdValid,
    output logic [TAG_BITS-1:0]   rdTag,
    output logic [DATA_WIDTH-1:0] rdData,
    input  logic                  wrEn,
    input  logic [INDEX_BITS-1:0] wrIndex,
    input  logic [TAG_BITS-1:0]   wrTag,
    input  logic [DATA_WIDTH-1:0] wrData
);

    logic [LINES-1:0]      validBits;
    logic [TAG_BITS-1:0]   tagArray  [LINES];
    logic [DATA_WIDTH-1:0] dataArray [LINES];

    // Only the valid bits need clearing; stale tag/data behind a clear bit is never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagArray[wrIndex]  <= wrTag;
            dataArray[wrIndex] <= wrData;
        end
    end

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagArray[rdIndex];
    assign rdData  = dataArray[rdIndex];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate cache in front of the 2048x64 RAM
module data_cache
    import data_cache_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_cache_if.slave           bus,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic                  ramIsReading,
    output logic [DATA_WIDTH-1:0] ramDataIn,
    input  logic [DATA_WIDTH-1:0] ramDataOut,
    output logic [15:0]           hitCount,
    output logic [15:0]           missCount
);

    localparam int WAIT_BITS = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [WAIT_BITS-1:0] WAIT_INIT = WAIT_BITS'(RAM_LATENCY - 1);

    cacheState_t           state;
    logic [WAIT_BITS-1:0]  waitCount;
    logic [ADDR_WIDTH-1:0] lookupAddress;
    logic                  lineValid;
    logic [TAG_BITS-1:0]   lineTag;
    logic [DATA_WIDTH-1:0] lineData;
    logic                  lineHit;
    logic                  accept;
    logic                  lastCycle;
    logic                  storeWrEn;
    logic [DATA_WIDTH-1:0] storeWrData;

    // In IDLE the lookup serves the incoming request; otherwise it tracks the latched one.
    assign lookupAddress = (state == IDLE) ? bus.cpuAddress : ramAddress;
    assign lineHit       = lineValid && (lineTag == getTag(lookupAddress));
    assign bus.cpuReady  = (state == IDLE);
    assign accept        = bus.cpuReq && bus.cpuReady;
    assign lastCycle     = (waitCount == '0);
    assign storeWrEn     = lastCycle && ((state == FILL) || ((state == WRITE) && lineHit));
    assign storeWrData   = (state == FILL) ? ramDataOut : ramDataIn;

    cache_line_store u_lineStore (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdIndex (getIndex(lookupAddress)),
        .rdValid (lineValid),
        .rdTag   (lineTag),
        .rdData  (lineData),
        .wrEn    (storeWrEn),
        .wrIndex (getIndex(ramAddress)),
        .wrTag   (getTag(ramAddress)),
        .wrData  (storeWrData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            waitCount        <= '0;
            bus.cpuRespValid <= 1'b0;
            bus.cpuReadData  <= '0;
            ramAddress       <= '0;
            ramDataIn        <= '0;
            ramIsReading     <= 1'b1;
            hitCount         <= '0;
            missCount        <= '0;
        end else begin
            bus.cpuRespValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.cpuWrite) begin
                            ramAddress   <= bus.cpuAddress;
                            ramDataIn    <= bus.cpuWriteData;
                            ramIsReading <= 1'b0;
                            waitCount    <= WAIT_INIT;
                            state        <= WRITE;
                        end else if (lineHit) begin
                            bus.cpuReadData  <= lineData;
                            bus.cpuRespValid <= 1'b1;
                            if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
                        end else begin
                            ramAddress <= bus.cpuAddress;
                            waitCount  <= WAIT_INIT;
                            state      <= FILL;
                            if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
                        end
                    end
                end
                FILL: begin
                    if (lastCycle) begin
                        bus.cpuReadData  <= ramDataOut;
                        bus.cpuRespValid <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        waitCount <= waitCount - 1'b1;
                    end
                end
                WRITE: begin
                    if (lastCycle) begin
                        ramIsReading     <= 1'b1;
                        bus.cpuRespValid <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        waitCount <= waitCount - 1'b1;
                    end
                end
                default: begin
                    ramIsReading <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache with a level-sensitive RAM model
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int RAM_LATENCY = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_cache_if bus ();

    logic [ADDR_WIDTH-1:0] ramAddress;
    logic                  ramIsReading;
    logic [DATA_WIDTH-1:0] ramDataIn;
    logic [DATA_WIDTH-1:0] ramDataOut;
    logic [15:0]           hitCount;
    logic [15:0]           missCount;

    data_cache #(.RAM_LATENCY(RAM_LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ramAddress   (ramAddress),
        .ramIsReading (ramIsReading),
        .ramDataIn    (ramDataIn),
        .ramDataOut   (ramDataOut),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    logic [DATA_WIDTH-1:0] ram [2048];
    logic                  clearRam = 1'b1;
    logic                  bdEn = 1'b0;
    logic [ADDR_WIDTH-1:0] bdAddr = '0;
    logic [DATA_WIDTH-1:0] bdData = '0;

    always @(posedge clk) begin
        if (clearRam) begin
            for (int i = 0; i < 2048; i++) ram[i] <= '0;
        end else if (bdEn) begin
            ram[bdAddr] <= bdData;
        end else if (!ramIsReading) begin
            ram[ramAddress] <= ramDataIn;
        end
    end
    assign ramDataOut = ram[ramAddress];

    int total = 0;
    int bad = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, return edges until the response pulse, the read data and how many
    // observed cycles had ramIsReading low.
    task automatic issue(input logic w, input logic [10:0] a, input logic [63:0] d,
                         output int lat, output logic [63:0] rd, output int lowCycles);
        int n;
        bus.cpuReq = 1'b1;
        bus.cpuWrite = w;
        bus.cpuAddress = a;
        bus.cpuWriteData = d;
        n = 0;
        while (!bus.cpuReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.cpuReq = 1'b0;
        lat = 1;
        lowCycles = 0;
        while (!bus.cpuRespValid && lat < 50) begin
            if (!ramIsReading) lowCycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.cpuReadData;
    endtask

    int lat;
    int low;
    logic [63:0] rd;

    initial begin
        bus.cpuReq = 1'b0;
        bus.cpuWrite = 1'b0;
        bus.cpuAddress = '0;
        bus.cpuWriteData = '0;
        repeat (2) @(posedge clk);
        bdEn = 1'b1;
        clearRam = 1'b0;
        bdAddr = 11'd1088;
        bdData = 64'h5555;
        @(posedge clk);
        #1;
        bdEn = 1'b0;

        checkVal("rst_ready", bus.cpuReady, 1);
        checkVal("rst_resp", bus.cpuRespValid, 0);
        checkVal("rst_rdata", bus.cpuReadData, 0);
        checkVal("rst_ramaddr", ramAddress, 0);
        checkVal("rst_ramrd", ramIsReading, 1);
        checkVal("rst_counts", {hitCount, missCount}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write-through to an uncached address
        issue(1'b1, 11'd1024, 64'hFF04, lat, rd, low);
        checkVal("w1_lat", lat, RAM_LATENCY + 1);
        checkVal("w1_low", low, RAM_LATENCY);
        checkVal("w1_ramrd_after", ramIsReading, 1);
        checkVal("w1_ram", ram[1024], 64'hFF04);
        checkVal("w1_counts", {hitCount, missCount}, 0);
        @(posedge clk);
        #1;
        checkVal("w1_pulse", bus.cpuRespValid, 0);

        // 2: read miss fills the line
        issue(1'b0, 11'd1024, 0, lat, rd, low);
        checkVal("r2_lat", lat, RAM_LATENCY + 1);
        checkVal("r2_data", rd, 64'hFF04);
        checkVal("r2_miss", missCount, 1);

        // 3: read hit, back-to-back from the response cycle
        issue(1'b0, 11'd1024, 0, lat, rd, low);
        checkVal("r3_lat", lat, 1);
        checkVal("r3_data", rd, 64'hFF04);
        checkVal("r3_low", low, 0);
        checkVal("r3_ramrd", ramIsReading, 1);
        checkVal("r3_hit", hitCount, 1);

        // 4: same index, different tag evicts
        issue(1'b0, 11'd1088, 0, lat, rd, low);
        checkVal("r4a_lat", lat, 2);
        checkVal("r4a_data", rd, 64'h5555);
        issue(1'b0, 11'd1024, 0, lat, rd, low);
        checkVal("r4b_lat", lat, 2);
        checkVal("r4b_data", rd, 64'hFF04);
        checkVal("r4b_miss", missCount, 3);
        issue(1'b0, 11'd1023, 0, lat, rd, low);
        checkVal("r4c_lat", lat, 2);
        checkVal("r4c_data", rd, 0);
        checkVal("r4c_miss", missCount, 4);

        // 5: write hit updates line; write miss does not allocate
        issue(1'b1, 11'd1024, 64'h1234, lat, rd, low);
        checkVal("w5_lat", lat, 2);
        issue(1'b0, 11'd1024, 0, lat, rd, low);
        checkVal("w5_ram", ram[1024], 64'h1234);
        checkVal("r5_lat", lat, 1);
        checkVal("r5_data", rd, 64'h1234);
        checkVal("r5_hit", hitCount, 2);
        issue(1'b1, 11'd1088, 64'h77, lat, rd, low);
        checkVal("w5b_ram", ram[1088], 64'h77);
        issue(1'b0, 11'd1088, 0, lat, rd, low);
        checkVal("r5b_lat", lat, 2);
        checkVal("r5b_data", rd, 64'h77);
        checkVal("r5b_counts", {hitCount, missCount}, {16'd2, 16'd5});

        // 6: reset mid-WRITE and mid-FILL
        @(negedge clk);
        bus.cpuReq = 1'b1;
        bus.cpuWrite = 1'b1;
        bus.cpuAddress = 11'd5;
        bus.cpuWriteData = 64'h99;
        @(posedge clk);
        #1;
        bus.cpuReq = 1'b0;
        checkVal("r6w_low", ramIsReading, 0);
        rst_n = 1'b0;
        #1;
        checkVal("r6w_ramrd", ramIsReading, 1);
        checkVal("r6w_resp", bus.cpuRespValid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.cpuReq = 1'b1;
        bus.cpuWrite = 1'b0;
        bus.cpuAddress = 11'd1024;
        @(posedge clk);
        #1;
        bus.cpuReq = 1'b0;
        checkVal("r6f_busy", bus.cpuReady, 0);
        rst_n = 1'b0;
        #1;
        checkVal("r6f_ramrd", ramIsReading, 1);
        checkVal("r6f_resp", bus.cpuRespValid, 0);
        checkVal("r6f_ready", bus.cpuReady, 1);
        @(negedge clk);
        rst_n = 1'b1;
        checkVal("r6_counts", {hitCount, missCount}, 0);
        checkVal("r6_ram5", ram[5], 0);
        @(negedge clk);
        issue(1'b0, 11'd1024, 0, lat, rd, low);
        checkVal("r6_lat", lat, 2);
        checkVal("r6_data", rd, 64'h1234);
        checkVal("r6_miss", {hitCount, missCount}, {16'd0, 16'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
